// File: rtl/serial_comparator_lsb.sv
// Bit-serial LSB-first magnitude comparator for two unsigned WIDTH-bit operands.
// Each accepted bit pair is less significant than every later pair. A later
// differing pair therefore overrides any earlier greater/less decision.
//
// Handshake: Busy is the ready signal and Bit_Valid is the valid signal.
// A bit pair on A_Bit/B_Bit is consumed on a rising edge only when both are 1
// in the cycle before that edge and Start is 0. A Start in RUN restarts the
// comparison and discards the pair offered in the same cycle. Bit_Valid is
// ignored whenever Busy is 0. The producer may hold Bit_Valid low for any
// number of cycles in RUN without losing state.
module serial_comparator_lsb #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Start,
  input  logic          Bit_Valid,
  input  logic          A_Bit,
  input  logic          B_Bit,
  output logic          Busy,
  output logic          Done,
  output logic          Eq_Out,
  output logic          Gr_Out,
  output logic          Ls_Out,
  output logic [CW-1:0] Bit_Cnt,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t        state_q, state_d;
  logic          eq_q, eq_d;
  logic          gr_q, gr_d;
  logic [CW-1:0] cnt_d;
  logic          load_result;

  assign dbg_state = state_q;

  // Next-state and working-register update; the result is latched on entry to DONE.
  always_comb begin
    state_d     = state_q;
    eq_d        = eq_q;
    gr_d        = gr_q;
    cnt_d       = Bit_Cnt;
    load_result = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          eq_d    = 1'b1;
          gr_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (Start) begin
          // Abort and restart; the pair offered this cycle is dropped.
          eq_d  = 1'b1;
          gr_d  = 1'b0;
          cnt_d = '0;
        end else if (Bit_Valid) begin
          eq_d = eq_q & (A_Bit ~^ B_Bit);
          if (A_Bit != B_Bit) begin
            gr_d = A_Bit & ~B_Bit;
          end
          cnt_d = Bit_Cnt + 1'b1;
          if (Bit_Cnt == LAST_CNT) begin
            state_d     = DONE;
            load_result = 1'b1;
          end
        end
      end
      DONE: begin
        if (Start) begin
          state_d = RUN;
          eq_d    = 1'b1;
          gr_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and working registers; Busy/Done come from the next state so they stay registered.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      eq_q    <= 1'b1;
      gr_q    <= 1'b0;
      Bit_Cnt <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_d;
      eq_q    <= eq_d;
      gr_q    <= gr_d;
      Bit_Cnt <= cnt_d;
      Busy    <= (state_d == RUN);
      Done    <= (state_d == DONE);
    end
  end

  // Result registers update only when a comparison completes and otherwise hold.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Eq_Out <= 1'b0;
      Gr_Out <= 1'b0;
      Ls_Out <= 1'b0;
    end else if (load_result) begin
      Eq_Out <= eq_d;
      Gr_Out <= gr_d;
      Ls_Out <= ~eq_d & ~gr_d;
    end
  end

endmodule
